// File: rtl/pixel_mem_pkg.sv
// Shared types for the pixel frame-memory AXI4 write slave: burst FSM states and BRESP codes.
package pixel_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        RESP
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/pixel_mem_sram.sv
// Simple dual-port frame RAM: one write port, one registered read port, read-before-write.
module pixel_mem_sram #(
    parameter int unsigned DATA_W = 256,
    parameter int unsigned DEPTH  = 1024,
    localparam int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [IDX_W-1:0]  raddr_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              rvld_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;
    logic              rvld_q;

    // Storage is intentionally not reset so frame contents survive a controller reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= '0;
            rvld_q  <= 1'b0;
        end else begin
            rvld_q <= re_i;
            if (re_i) begin
                rdata_q <= mem_q[raddr_i];
            end
        end
    end

    assign rdata_o = rdata_q;
    assign rvld_o  = rvld_q;

endmodule

// File: rtl/pixel_mem_axi4_slave.sv
// AXI4 write slave storing pixel beats into frame memory, with a read port and frame-done strobe.
// Optional PXL_MEM_BOUNDS_CHECK_EN: out-of-range beats are dropped and answered with SLVERR.
module pixel_mem_axi4_slave
    import pixel_mem_pkg::*;
#(
    parameter int unsigned        DATA_W        = 256,
    parameter int unsigned        ADDR_W        = 32,
    parameter int unsigned        MST_ID_W      = 5,
    parameter int unsigned        TRANS_RESP_W  = 2,
    parameter logic [ADDR_W-1:0]  MEM_BASE_ADDR = 32'h8000_0000,
    parameter int unsigned        MEM_DEPTH     = 1024,
    parameter int unsigned        FRAME_BEATS   = 600
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [MST_ID_W-1:0]           s_awid_i,
    input  logic [ADDR_W-1:0]             s_awaddr_i,
    input  logic                          s_awvalid_i,
    output logic                          s_awready_o,
    input  logic [DATA_W-1:0]             s_wdata_i,
    input  logic                          s_wlast_i,
    input  logic                          s_wvalid_i,
    output logic                          s_wready_o,
    output logic [MST_ID_W-1:0]           s_bid_o,
    output logic [TRANS_RESP_W-1:0]       s_bresp_o,
    output logic                          s_bvalid_o,
    input  logic                          s_bready_i,
    input  logic                          rd_en_i,
    input  logic [$clog2(MEM_DEPTH)-1:0]  rd_addr_i,
    output logic [DATA_W-1:0]             rd_data_o,
    output logic                          rd_vld_o,
    output logic                          frame_done_o
);

    localparam int unsigned IDX_W   = $clog2(MEM_DEPTH);
    localparam int unsigned BYTE_SH = $clog2(DATA_W / 8);
    localparam int unsigned FCNT_W  = $clog2(FRAME_BEATS + 1);

    state_e                  state_q, state_d;
    logic                    awready_q, awready_d;
    logic                    wready_q, wready_d;
    logic                    bvalid_q, bvalid_d;
    logic [MST_ID_W-1:0]     id_q, id_d;
    logic [TRANS_RESP_W-1:0] bresp_q, bresp_d;
    logic [ADDR_W-1:0]       ptr_q, ptr_d;
    logic                    err_q, err_d;
    logic [FCNT_W-1:0]       fcnt_q, fcnt_d;
    logic                    frame_done_q, frame_done_d;

    logic                    aw_hs, w_hs, b_hs, beat_ok, mem_we;
    logic [ADDR_W-1:0]       aw_off;

    assign aw_hs  = s_awvalid_i & awready_q;
    assign w_hs   = s_wvalid_i & wready_q;
    assign b_hs   = bvalid_q & s_bready_i;
    assign aw_off = s_awaddr_i - MEM_BASE_ADDR;

`ifdef PXL_MEM_BOUNDS_CHECK_EN
    assign beat_ok = (ptr_q < ADDR_W'(MEM_DEPTH));
`else
    assign beat_ok = 1'b1;
`endif

    // A beat accepted in the same cycle reset asserts must not reach memory.
    assign mem_we = w_hs & beat_ok & rst_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            awready_q    <= 1'b0;
            wready_q     <= 1'b0;
            bvalid_q     <= 1'b0;
            id_q         <= '0;
            bresp_q      <= '0;
            ptr_q        <= '0;
            err_q        <= 1'b0;
            fcnt_q       <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            awready_q    <= awready_d;
            wready_q     <= wready_d;
            bvalid_q     <= bvalid_d;
            id_q         <= id_d;
            bresp_q      <= bresp_d;
            ptr_q        <= ptr_d;
            err_q        <= err_d;
            fcnt_q       <= fcnt_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        id_d         = id_q;
        ptr_d        = ptr_q;
        err_d        = err_q;
        bresp_d      = bresp_q;
        fcnt_d       = fcnt_q;
        frame_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (aw_hs) begin
                    state_d = DATA;
                    id_d    = s_awid_i;
                    ptr_d   = aw_off >> BYTE_SH;
                    err_d   = 1'b0;
`ifdef PXL_MEM_BOUNDS_CHECK_EN
                    if (s_awaddr_i < MEM_BASE_ADDR) begin
                        err_d = 1'b1;
                    end
`endif
                end
            end
            DATA: begin
                if (w_hs) begin
                    ptr_d = ptr_q + ADDR_W'(1);
                    if (!beat_ok) begin
                        err_d = 1'b1;
                    end
                    if (s_wlast_i) begin
                        state_d = RESP;
                        bresp_d = err_d ? TRANS_RESP_W'(RESP_SLVERR) : TRANS_RESP_W'(RESP_OKAY);
                    end
                end
            end
            RESP: begin
                if (b_hs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Frame counter tracks stored beats only.
        if (mem_we) begin
            if (fcnt_q == FCNT_W'(FRAME_BEATS - 1)) begin
                fcnt_d       = '0;
                frame_done_d = 1'b1;
            end else begin
                fcnt_d = fcnt_q + FCNT_W'(1);
            end
        end
    end

    assign awready_d = (state_d == IDLE);
    assign wready_d  = (state_d == DATA);
    assign bvalid_d  = (state_d == RESP);

    assign s_awready_o  = awready_q;
    assign s_wready_o   = wready_q;
    assign s_bvalid_o   = bvalid_q;
    assign s_bid_o      = id_q;
    assign s_bresp_o    = bresp_q;
    assign frame_done_o = frame_done_q;

    pixel_mem_sram #(
        .DATA_W (DATA_W),
        .DEPTH  (MEM_DEPTH)
    ) u_sram (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (mem_we),
        .waddr_i (ptr_q[IDX_W-1:0]),
        .wdata_i (s_wdata_i),
        .re_i    (rd_en_i),
        .raddr_i (rd_addr_i),
        .rdata_o (rd_data_o),
        .rvld_o  (rd_vld_o)
    );

endmodule
